branch_predictor: RTL and testbench

Fetch-stage branch predictor for the RV32I pipeline: a direct-mapped branch target buffer with 2-bit saturating counters. It supplies a predicted next PC in IF. It learns from the branch outcome resolved in EX, which is the taken/not-taken result of the BranchDecider plus the computed target. It also raises a mispredict/redirect that flushes IF/ID.

---
 rtl/bp_pkg.sv | 14 +
 rtl/sat_ctr2.sv | 11 +
 rtl/branch_predictor.sv | 82 ++++++++
 tb/tb_branch_predictor.sv | 116 +++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared constants and PC slicing helpers for the branch predictor
package bp_pkg;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  function automatic logic [31:0] bp_idx(input logic [31:0] pc, input int idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction
  function automatic logic [31:0] bp_tag(input logic [31:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction
endpackage

// File: rtl/sat_ctr2.sv
// sat_ctr2: combinational next state of a 2-bit saturating counter
module sat_ctr2
  import bp_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);
  assign nxt = taken ? ((cur == ST) ? ST : cur + 2'd1)
                     : ((cur == SNT) ? SNT : cur - 2'd1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters; optional BP_STATS_EN statistics
module branch_predictor
  import bp_pkg::*;
#(
  parameter int          ENTRIES   = 16,
  parameter logic [1:0]  RESET_CTR = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [29:0]        r_tgt [ENTRIES];
  logic [1:0]         r_ctr [ENTRIES];
  logic [IDX_W-1:0]   w_f_idx, w_e_idx;
  logic [TAG_W-1:0]   w_f_tag, w_e_tag;
  logic               w_f_hit, w_e_hit, w_res;
  logic [1:0]         w_ctr_nxt;
  assign w_f_idx = IDX_W'(bp_idx(pc_f, IDX_W));
  assign w_f_tag = TAG_W'(bp_tag(pc_f, IDX_W));
  assign w_e_idx = IDX_W'(bp_idx(ex_pc, IDX_W));
  assign w_e_tag = TAG_W'(bp_tag(ex_pc, IDX_W));
  assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_e_hit = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
  assign w_res   = ex_valid && ex_is_branch && !rst;
  assign pred_taken  = !rst && w_f_hit && r_ctr[w_f_idx][1];
  assign pred_target = pred_taken ? {r_tgt[w_f_idx], 2'b00} : pc_f + 32'd4;
  assign mispredict  = w_res && ((ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target)));
  assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
  sat_ctr2 u_ctr (.cur(r_ctr[w_e_idx]), .taken(ex_taken), .nxt(w_ctr_nxt));
  // table update: train on hits, allocate on taken misses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= RESET_CTR;
    end else if (w_res) begin
      if (w_e_hit) begin
        r_ctr[w_e_idx] <= w_ctr_nxt;
        if (ex_taken) r_tgt[w_e_idx] <= ex_target[31:2];
      end else if (ex_taken) begin
        r_valid[w_e_idx] <= 1'b1;
        r_tag[w_e_idx]   <= w_e_tag;
        r_tgt[w_e_idx]   <= ex_target[31:2];
        r_ctr[w_e_idx]   <= WT;
      end
    end
  end
`ifdef BP_STATS_EN
  logic [31:0] r_branches, r_mispredicts;
  // resolved-branch and mispredict counters, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branches    <= '0;
      r_mispredicts <= '0;
    end else if (w_res) begin
      r_branches    <= r_branches + 32'd1;
      r_mispredicts <= r_mispredicts + {31'd0, mispredict};
    end
  end
  assign stat_branches    = r_branches;
  assign stat_mispredicts = r_mispredicts;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor
module tb_branch_predictor;
  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] pc_f = 32'h100;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 0, ex_is_branch = 0, ex_taken = 0, ex_pred_taken = 0;
  logic [31:0] ex_pc = 0, ex_target = 0, ex_pred_target = 0;
  logic        mispredict;
  logic [31:0] redirect_pc, stat_branches, stat_mispredicts;
  int total = 0, bad = 0, exp_br = 0, exp_mi = 0;

  branch_predictor dut (
    .clk(clk), .rst(rst), .pc_f(pc_f), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    pc_f = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, t});
    chk({tag, "_target"}, pred_target, tgt);
  endtask

  task automatic resolve(input string tag, input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt, input logic em, input logic [31:0] er);
    ex_valid = 1; ex_is_branch = 1; ex_pc = pc; ex_taken = t; ex_target = tgt;
    ex_pred_taken = pt; ex_pred_target = ptgt;
    #1;
    chk({tag, "_mis"}, {31'd0, mispredict}, {31'd0, em});
    chk({tag, "_redir"}, redirect_pc, er);
    exp_br++;
    if (em) exp_mi++;
    step();
    ex_valid = 0; ex_is_branch = 0;
  endtask

  initial begin
    ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h100; ex_taken = 1; ex_target = 32'h80;
    ex_pred_taken = 0; ex_pred_target = 32'h104;
    #1;
    chk("rst_mis", {31'd0, mispredict}, 32'd0);
    chk("rst_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_target", pred_target, 32'h104);
    step();
    rst = 0; ex_valid = 0; ex_is_branch = 0;
    look("post_rst", 32'h100, 0, 32'h104);
    chk("post_rst_br", stat_branches, 32'd0);
    pc_f = 32'h100;
    resolve("cold", 32'h100, 1, 32'h80, 0, 32'h104, 1, 32'h80);
    look("cold_hit", 32'h100, 1, 32'h80);
    resolve("t2", 32'h100, 1, 32'h80, 1, 32'h80, 0, 32'h80);
    resolve("t3", 32'h100, 1, 32'h80, 1, 32'h80, 0, 32'h80);
    resolve("nt1", 32'h100, 0, 32'h80, 1, 32'h80, 1, 32'h104);
    look("after_nt1", 32'h100, 1, 32'h80);
    resolve("nt2", 32'h100, 0, 32'h80, 1, 32'h80, 1, 32'h104);
    look("after_nt2", 32'h100, 0, 32'h104);
    resolve("wtgt", 32'h100, 1, 32'h90, 1, 32'h80, 1, 32'h90);
    look("new_tgt", 32'h100, 1, 32'h90);
    look("alias_miss", 32'h140, 0, 32'h144);
    resolve("alias", 32'h140, 1, 32'h200, 0, 32'h144, 1, 32'h200);
    look("evicted", 32'h100, 0, 32'h104);
    look("alias_hit", 32'h140, 1, 32'h200);
    resolve("ntmiss", 32'h104, 0, 32'h300, 0, 32'h108, 0, 32'h108);
    look("no_alloc", 32'h104, 0, 32'h108);
    ex_valid = 0; ex_is_branch = 1; ex_pc = 32'h108; ex_taken = 1; ex_target = 32'h300;
    ex_pred_taken = 0; ex_pred_target = 32'h10C;
    #1;
    chk("bubble_mis", {31'd0, mispredict}, 32'd0);
    step();
    ex_valid = 1; ex_is_branch = 0;
    #1;
    chk("nonbr_mis", {31'd0, mispredict}, 32'd0);
    step();
    ex_valid = 0;
    look("bubble_noalloc", 32'h108, 0, 32'h10C);
    look("wrap_pc", 32'hFFFFFFFC, 0, 32'h0);
    resolve("wrap_nt", 32'hFFFFFFFC, 0, 32'h10, 0, 32'h0, 0, 32'h0);
    resolve("unal", 32'h10C, 1, 32'h203, 0, 32'h110, 1, 32'h203);
    look("aligned_tgt", 32'h10C, 1, 32'h200);
`ifdef BP_STATS_EN
    chk("stat_br", stat_branches, exp_br);
    chk("stat_mi", stat_mispredicts, exp_mi);
`else
    chk("stat_br_off", stat_branches, 32'd0);
    chk("stat_mi_off", stat_mispredicts, 32'd0);
`endif
    rst = 1;
    step();
    rst = 0;
    chk("rst2_br", stat_branches, 32'd0);
    chk("rst2_mi", stat_mispredicts, 32'd0);
    look("rst2_clear", 32'h140, 0, 32'h144);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
